// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage indices, FSM state type and stall/flush vector
// constants for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STG = 5;

  // Pipeline register indices within stall/flush vectors
  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IFID   = 1;
  localparam int unsigned STG_IDEXE  = 2;
  localparam int unsigned STG_EXEMEM = 3;
  localparam int unsigned STG_MEMWB  = 4;

  typedef logic [NUM_STG-1:0] stg_vec_t;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_BUSY   = 2'd1,
    PC_DRAIN  = 2'd2,
    PC_HALTED = 2'd3
  } pc_state_e;

  // One-hot vector selecting a single pipeline register
  function automatic stg_vec_t stg_bit(input int unsigned idx);
    stg_bit = stg_vec_t'(1) << idx;
  endfunction

  localparam stg_vec_t STALL_NONE  = '0;
  localparam stg_vec_t STALL_BUSY  = stg_bit(STG_PC) | stg_bit(STG_IFID) | stg_bit(STG_IDEXE);
  localparam stg_vec_t STALL_LOAD  = stg_bit(STG_PC) | stg_bit(STG_IFID);
  localparam stg_vec_t STALL_HALT  = stg_bit(STG_PC);

  localparam stg_vec_t FLUSH_NONE  = '0;
  localparam stg_vec_t FLUSH_BUSY  = stg_bit(STG_EXEMEM);
  localparam stg_vec_t FLUSH_LOAD  = stg_bit(STG_IDEXE);
  localparam stg_vec_t FLUSH_JUMP  = stg_bit(STG_IFID) | stg_bit(STG_IDEXE);
  localparam stg_vec_t FLUSH_HALT  = stg_bit(STG_IFID);
  // The PC has no NOP form, so bit 0 is never a flush
  localparam stg_vec_t FLUSH_RESET = stg_bit(STG_IFID) | stg_bit(STG_IDEXE) |
                                     stg_bit(STG_EXEMEM) | stg_bit(STG_MEMWB);

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard requests into the controller and stall/flush/redirect
// controls back to the pipeline. The controller uses the slave modport; the
// pipeline (or a bench) drives through the master modport.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) ();
  import pipe_ctrl_pkg::*;

  logic                  stallreq_id_i;
  logic                  exe_busy_i;
  logic                  jump_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;
  logic                  halt_req_i;

  stg_vec_t              stall_o;
  stg_vec_t              flush_o;
  logic                  redirect_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic                  halted_o;
  logic                  timeout_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;

  modport master (
    output stallreq_id_i, exe_busy_i, jump_i, jump_addr_i, halt_req_i,
    input  stall_o, flush_o, redirect_o, redirect_pc_o, halted_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stallreq_id_i, exe_busy_i, jump_i, jump_addr_i, halt_req_i,
    output stall_o, flush_o, redirect_o, redirect_pc_o, halted_o, timeout_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating stall-cycle and redirect counters for the
// pipeline controller (instantiated only when PIPE_CTRL_PERF_EN is defined).
module pipe_ctrl_perf #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 stall_inc_i,
  input  logic                 flush_inc_i,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Increment on request, holding at all-ones once reached
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the 5-stage RV32I pipeline.
// Merges load-use, EXE busy, EXE redirect and debug halt into per-register
// stall/flush vectors; owns the halt/drain FSM and the EXE busy watchdog.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/redirect counters;
// without it stall_cnt_o/flush_cnt_o read 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned BCW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int unsigned DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [BCW-1:0] BUSY_LAST  = BCW'(BUSY_TIMEOUT - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  pc_state_e             state_q, state_d;
  logic [BCW-1:0]        busy_cnt_q, busy_cnt_d;
  logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
  logic                  origin_drain_q, origin_drain_d;
  logic                  mask_q, mask_d;
  logic                  timeout_q, timeout_d;

  logic                  busy_eff;
  stg_vec_t              stall, flush;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]  stall_cnt, flush_cnt;

  // After a watchdog trip a stuck busy is ignored until it is seen low once
  assign busy_eff = bus.exe_busy_i && !mask_q;

  // Per-cycle stall/flush/redirect outputs and FSM next state
  always_comb begin
    state_d        = state_q;
    busy_cnt_d     = busy_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    origin_drain_d = origin_drain_q;
    timeout_d      = timeout_q;
    mask_d         = mask_q && bus.exe_busy_i;
    stall          = STALL_NONE;
    flush          = FLUSH_NONE;
    redirect       = 1'b0;
    redirect_pc    = '0;

    if (state_q == PC_HALTED) begin
      stall = STALL_HALT;
      flush = FLUSH_HALT;
    end else if (busy_eff) begin
      // EXE keeps any pending jump until it is no longer busy
      stall = STALL_BUSY;
      flush = FLUSH_BUSY;
    end else begin
      if (bus.jump_i) begin
        flush       = FLUSH_JUMP;
        redirect    = 1'b1;
        redirect_pc = bus.jump_addr_i;
      end else if (bus.stallreq_id_i) begin
        stall = STALL_LOAD;
        flush = FLUSH_LOAD;
      end
      // Draining: freeze the PC and keep bubbling fetch; a redirect still
      // wins so the PC ends up holding the resume point
      if (state_q == PC_DRAIN) begin
        stall = stall | stg_bit(STG_PC);
        flush = flush | stg_bit(STG_IFID);
      end
    end

    case (state_q)
      PC_RUN: begin
        if (busy_eff) begin
          state_d        = PC_BUSY;
          busy_cnt_d     = BCW'(1);
          origin_drain_d = 1'b0;
        end else if (bus.halt_req_i) begin
          state_d     = PC_DRAIN;
          drain_cnt_d = '0;
        end
      end
      PC_BUSY: begin
        if (!busy_eff) begin
          state_d    = origin_drain_q ? PC_DRAIN : PC_RUN;
          busy_cnt_d = '0;
        end else if (busy_cnt_q == BUSY_LAST) begin
          state_d    = origin_drain_q ? PC_DRAIN : PC_RUN;
          busy_cnt_d = '0;
          timeout_d  = 1'b1;
          mask_d     = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      PC_DRAIN: begin
        // Drain count stays frozen across the BUSY excursion
        if (busy_eff) begin
          state_d        = PC_BUSY;
          busy_cnt_d     = BCW'(1);
          origin_drain_d = bus.halt_req_i;
          if (!bus.halt_req_i) drain_cnt_d = '0;
        end else if (!bus.halt_req_i) begin
          state_d     = PC_RUN;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = PC_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      PC_HALTED: begin
        if (!bus.halt_req_i) begin
          state_d     = PC_RUN;
          drain_cnt_d = '0;
        end
      end
      default: state_d = PC_RUN;
    endcase

    if (!rst_n_i) begin
      stall       = STALL_NONE;
      flush       = FLUSH_RESET;
      redirect    = 1'b0;
      redirect_pc = '0;
    end
  end

  // State, counters and sticky watchdog flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= PC_RUN;
      busy_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      origin_drain_q <= 1'b0;
      mask_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_cnt_q     <= busy_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      origin_drain_q <= origin_drain_d;
      mask_q         <= mask_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .stall_inc_i (stall[STG_PC]),
    .flush_inc_i (redirect),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.redirect_o    = redirect;
  assign bus.redirect_pc_o = redirect_pc;
  assign bus.halted_o      = (state_q == PC_HALTED);
  assign bus.timeout_o     = timeout_q;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand sequences for busy watchdog,
// halt/drain and reset-during-drain.
module tb_pipe_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

  pipe_ctrl #(
    .ADDR_WIDTH   (32),
    .DRAIN_CYCLES (4),
    .BUSY_TIMEOUT (8),
    .CNT_WIDTH    (32)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sr;
    logic        busy;
    logic        jmp;
    logic [31:0] addr;
    logic [4:0]  es;
    logic [4:0]  ef;
    logic        er;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [4:0] s, input logic [4:0] f,
                         input logic r, input logic [31:0] pc);
    chk({nm, ".stall"}, 32'(bus.stall_o), 32'(s));
    chk({nm, ".flush"}, 32'(bus.flush_o), 32'(f));
    chk({nm, ".redir"}, 32'(bus.redirect_o), 32'(r));
    chk({nm, ".pc"}, bus.redirect_pc_o, pc);
  endtask

  // Drive one cycle of inputs at the falling edge, settle before checking
  task automatic drive(input logic sr, input logic busy, input logic jmp,
                       input logic [31:0] addr, input logic hlt);
    @(negedge clk);
    bus.stallreq_id_i = sr;
    bus.exe_busy_i    = busy;
    bus.jump_i        = jmp;
    bus.jump_addr_i   = addr;
    bus.halt_req_i    = hlt;
    #2;
  endtask

  initial begin
    int exp_sc;
    int exp_fc;
    total = 0;
    bad   = 0;
    exp_sc = 0;
    exp_fc = 0;

    //                sr busy jmp addr          stall     flush     red pc
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'b00000, 5'b00000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  5'b00011, 5'b00100, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'b00000, 5'b00000, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h80, 5'b00000, 5'b00110, 1'b1, 32'h80};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h44, 5'b00111, 5'b01000, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h44, 5'b00111, 5'b01000, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h44, 5'b00111, 5'b01000, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h44, 5'b00000, 5'b00110, 1'b1, 32'h44};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,  5'b00111, 5'b01000, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  5'b00011, 5'b00100, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  5'b00000, 5'b00000, 1'b0, 32'h0};

    // Reset phase
    rst_n = 1'b0;
    bus.stallreq_id_i = 1'b0;
    bus.exe_busy_i    = 1'b0;
    bus.jump_i        = 1'b0;
    bus.jump_addr_i   = '0;
    bus.halt_req_i    = 1'b0;
    #3;
    chk_out("rst", 5'b00000, 5'b11110, 1'b0, 32'h0);
    chk("rst.halted", 32'(bus.halted_o), 32'h0);
    chk("rst.timeout", 32'(bus.timeout_o), 32'h0);
    chk("rst.scnt", bus.stall_cnt_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].sr, tbl[i].busy, tbl[i].jmp, tbl[i].addr, 1'b0);
      chk_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].ef, tbl[i].er, tbl[i].epc);
      chk($sformatf("vec%0d.halted", i), 32'(bus.halted_o), 32'h0);
      if (tbl[i].es[0]) exp_sc++;
      if (tbl[i].er) exp_fc++;
    end
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf.stall_cnt", bus.stall_cnt_o, 32'(exp_sc));
    chk("perf.flush_cnt", bus.flush_cnt_o, 32'(exp_fc));
`else
    chk("perf.stall_cnt", bus.stall_cnt_o, 32'h0);
    chk("perf.flush_cnt", bus.flush_cnt_o, 32'h0);
`endif

    // Watchdog: busy held 20 cycles, one jump while busy is masked
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, (i == 15), 32'h100, 1'b0);
      chk_out($sformatf("wd%0d", i),
              (i <= 8) ? 5'b00111 : 5'b00000,
              (i <= 8) ? 5'b01000 : ((i == 15) ? 5'b00110 : 5'b00000),
              (i == 15), (i == 15) ? 32'h100 : 32'h0);
      chk($sformatf("wd%0d.timeout", i), 32'(bus.timeout_o), (i >= 9) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("wd.low", 5'b00000, 5'b00000, 1'b0, 32'h0);
    chk("wd.sticky", 32'(bus.timeout_o), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_out("wd.rebusy", 5'b00111, 5'b01000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("wd.idle", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Halt: one RUN cycle, four drain cycles, then halted
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("h0", 5'b00000, 5'b00000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("h1", 5'b00001, 5'b00010, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("h2", 5'b00011, 5'b00110, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    chk_out("h3", 5'b00001, 5'b00110, 1'b1, 32'h200);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("h4", 5'b00001, 5'b00010, 1'b0, 32'h0);
    chk("h4.halted", 32'(bus.halted_o), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("h5", 5'b00001, 5'b00010, 1'b0, 32'h0);
    chk("h5.halted", 32'(bus.halted_o), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("h6.halted", 32'(bus.halted_o), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("h8", 5'b00000, 5'b00000, 1'b0, 32'h0);
    chk("h8.halted", 32'(bus.halted_o), 32'h0);

    // Halt request dropped mid-drain
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("hd1", 5'b00001, 5'b00010, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("hd3", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Reset asserted with drain_cnt at 2
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 32'h400;
    #2;
    chk_out("rdrn", 5'b00000, 5'b11110, 1'b0, 32'h0);
    chk("rdrn.halted", 32'(bus.halted_o), 32'h0);
    chk("rdrn.timeout", 32'(bus.timeout_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.jump_i     = 1'b0;
    bus.halt_req_i = 1'b0;
    #2;
    chk_out("rrel", 5'b00000, 5'b00000, 1'b0, 32'h0);
    chk("rrel.halted", 32'(bus.halted_o), 32'h0);
    // Back in RUN, a fresh halt request gives no drain terms on its first cycle
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("rrun", 5'b00000, 5'b00000, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("rdr1", 5'b00001, 5'b00010, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
